mult_leak_trial_sequencer: RTL and testbench

Upstream stimulus and result-collection stage for the two-copy constant-time multiplier tester. Generates pseudo-random operand pairs for both copies and pulses the shared start. Samples the tester's timingLeak / timingLeakDone outputs and accumulates campaign statistics: trials run, leaks detected, timeouts, and the index of the first leaking trial. Each campaign runs a fixed number of trials, one at a time.

---
 rtl/mult_leak_trial_sequencer_pkg.sv | 33 +++
 rtl/mult_leak_trial_sequencer_prng.sv | 29 ++
 rtl/mult_leak_trial_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_mult_leak_trial_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_leak_trial_sequencer_pkg.sv
// Shared definitions for the multiplier leak trial sequencer: FSM states,
// operand modes, the "no leak seen" marker and the xorshift32 step function.
package mult_leak_trial_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_START,
    S_WAIT,
    S_SETTLE,
    S_RECORD,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_RAND = 2'd0;
  localparam logic [1:0] MODE_ZERO = 2'd1;
  localparam logic [1:0] MODE_ONES = 2'd2;
  localparam logic [1:0] MODE_SAME = 2'd3;

  // Wide enough for any counter width; users take the low CNT_W bits.
  localparam logic [31:0] NO_LEAK_IDX = 32'hFFFF_FFFF;

  // One xorshift32 step: x^=x<<13; x^=x>>17; x^=x<<5.
  function automatic logic [31:0] xorshift32_next(input logic [31:0] i_x);
    logic [31:0] x;
    x = i_x;
    x = x ^ (x << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

endpackage

// File: rtl/mult_leak_trial_sequencer_prng.sv
// xorshift32 generator. A zero seed would lock the generator at zero, so it
// is replaced by 1 when loaded.
module xorshift32_prng
  import mult_leak_trial_sequencer_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_seed,
  input  logic        i_step,
  output logic [31:0] o_value
);

  logic [31:0] r_state;

  // Load has priority over step; the state only moves when asked to.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= 32'h1;
    end else if (i_load) begin
      r_state <= (i_seed == 32'h0) ? 32'h1 : i_seed;
    end else if (i_step) begin
      r_state <= xorshift32_next(r_state);
    end
  end

  assign o_value = r_state;

endmodule

// File: rtl/mult_leak_trial_sequencer.sv
// Trial sequencer for the two-copy constant-time multiplier tester: builds
// operand pairs word by word, pulses the tester, watches its leak outputs
// and keeps per-campaign statistics.
module mult_leak_trial_sequencer
  import mult_leak_trial_sequencer_pkg::*;
#(
  parameter int WIDTH      = 256,
  parameter int NUM_TRIALS = 1024,
  parameter int TIMEOUT    = 2*WIDTH+16,
  parameter int CNT_W      = $clog2(NUM_TRIALS+1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic [1:0]       i_mode,
  input  logic [31:0]      i_seed,
  output logic [WIDTH-1:0] o_multiplierOne,
  output logic [WIDTH-1:0] o_multiplicandOne,
  output logic [WIDTH-1:0] o_multiplierTwo,
  output logic [WIDTH-1:0] o_multiplicandTwo,
  output logic             o_mulStart,
  input  logic             i_timingLeak,
  input  logic             i_timingLeakDone,
  output logic             o_busy,
  output logic             o_campaignDone,
  output logic [CNT_W-1:0] o_trialCount,
  output logic [CNT_W-1:0] o_leakCount,
  output logic [CNT_W-1:0] o_timeoutCount,
  output logic [CNT_W-1:0] o_firstLeakIdx
);

  localparam int WORDS  = WIDTH / 32;
  localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BASE_W = WORD_W + 5;
  localparam int TO_W   = $clog2(TIMEOUT + 2);

  state_t             r_state;
  logic [1:0]         r_mode;
  logic [1:0]         r_opSel;
  logic [WORD_W-1:0]  r_wordIdx;
  logic [TO_W-1:0]    r_waitCnt;
  logic               r_leak;
  logic               r_timeout;
  logic [WIDTH-1:0]   r_mulOne, r_mcOne, r_mulTwo, r_mcTwo;
  logic               r_mulStart, r_busy, r_campaignDone;
  logic [CNT_W-1:0]   r_trialCount, r_leakCount, r_timeoutCount, r_firstLeakIdx;

  logic [31:0]        w_prngValue;
  logic [31:0]        w_nextWord;
  logic [BASE_W-1:0]  w_base;
  logic               w_load;
  logic               w_step;

  assign w_load     = (r_state == S_IDLE) && i_run;
  assign w_step     = (r_state == S_GEN);
  assign w_nextWord = xorshift32_next(w_prngValue);
  assign w_base     = {r_wordIdx, 5'b0};

  xorshift32_prng u_prng (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .i_seed  (i_seed),
    .i_step  (w_step),
    .o_value (w_prngValue)
  );

  // Campaign FSM: operand build, start pulse, result capture and statistics.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_mode         <= MODE_RAND;
      r_opSel        <= 2'd0;
      r_wordIdx      <= '0;
      r_waitCnt      <= '0;
      r_leak         <= 1'b0;
      r_timeout      <= 1'b0;
      r_mulOne       <= '0;
      r_mcOne        <= '0;
      r_mulTwo       <= '0;
      r_mcTwo        <= '0;
      r_mulStart     <= 1'b0;
      r_busy         <= 1'b0;
      r_campaignDone <= 1'b0;
      r_trialCount   <= '0;
      r_leakCount    <= '0;
      r_timeoutCount <= '0;
      r_firstLeakIdx <= NO_LEAK_IDX[CNT_W-1:0];
    end else begin
      r_mulStart     <= 1'b0;
      r_campaignDone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_run) begin
            r_mode         <= i_mode;
            r_trialCount   <= '0;
            r_leakCount    <= '0;
            r_timeoutCount <= '0;
            r_firstLeakIdx <= NO_LEAK_IDX[CNT_W-1:0];
            r_opSel        <= 2'd0;
            r_wordIdx      <= '0;
            r_busy         <= 1'b1;
            r_state        <= S_GEN;
          end
        end
        S_GEN: begin
          case (r_opSel)
            2'd0: r_mulOne[w_base +: 32] <= w_nextWord;
            2'd1: r_mcOne[w_base +: 32]  <= w_nextWord;
            2'd2: r_mulTwo[w_base +: 32] <= (r_mode == MODE_SAME) ? r_mulOne[w_base +: 32] : w_nextWord;
            default: begin
              case (r_mode)
                MODE_ZERO: r_mcTwo[w_base +: 32] <= 32'h0;
                MODE_ONES: r_mcTwo[w_base +: 32] <= 32'hFFFF_FFFF;
                MODE_SAME: r_mcTwo[w_base +: 32] <= r_mcOne[w_base +: 32];
                default:   r_mcTwo[w_base +: 32] <= w_nextWord;
              endcase
            end
          endcase
          if (r_wordIdx == WORD_W'(WORDS-1)) begin
            r_wordIdx <= '0;
            if (r_opSel == 2'd3) begin
              r_opSel    <= 2'd0;
              r_mulStart <= 1'b1;
              r_state    <= S_START;
            end else begin
              r_opSel <= r_opSel + 2'd1;
            end
          end else begin
            r_wordIdx <= r_wordIdx + WORD_W'(1);
          end
        end
        S_START: begin
          r_waitCnt <= TO_W'(1);
          r_leak    <= 1'b0;
          r_timeout <= 1'b0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (i_timingLeakDone) begin
            r_leak <= i_timingLeak;
            if (i_timingLeak) begin
              r_waitCnt <= r_waitCnt + TO_W'(1);
              r_state   <= S_SETTLE;
            end else begin
              r_state <= S_RECORD;
            end
          end else if (r_waitCnt >= TO_W'(TIMEOUT)) begin
            r_timeout <= 1'b1;
            r_leak    <= 1'b1;
            r_state   <= S_RECORD;
          end else begin
            r_waitCnt <= r_waitCnt + TO_W'(1);
          end
        end
        S_SETTLE: begin
          if (!i_timingLeak) begin
            r_state <= S_RECORD;
          end else if (r_waitCnt >= TO_W'(TIMEOUT)) begin
            r_timeout <= 1'b1;
            r_state   <= S_RECORD;
          end else begin
            r_waitCnt <= r_waitCnt + TO_W'(1);
          end
        end
        S_RECORD: begin
          r_trialCount <= r_trialCount + CNT_W'(1);
          if (r_leak) begin
            r_leakCount <= r_leakCount + CNT_W'(1);
            if (r_firstLeakIdx == NO_LEAK_IDX[CNT_W-1:0]) begin
              r_firstLeakIdx <= r_trialCount;
            end
          end
          if (r_timeout) begin
            r_timeoutCount <= r_timeoutCount + CNT_W'(1);
          end
          if (r_trialCount == CNT_W'(NUM_TRIALS-1)) begin
            r_campaignDone <= 1'b1;
            r_state        <= S_DONE;
          end else begin
            r_state <= S_GEN;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_multiplierOne   = r_mulOne;
  assign o_multiplicandOne = r_mcOne;
  assign o_multiplierTwo   = r_mulTwo;
  assign o_multiplicandTwo = r_mcTwo;
  assign o_mulStart        = r_mulStart;
  assign o_busy            = r_busy;
  assign o_campaignDone    = r_campaignDone;
  assign o_trialCount      = r_trialCount;
  assign o_leakCount       = r_leakCount;
  assign o_timeoutCount    = r_timeoutCount;
  assign o_firstLeakIdx    = r_firstLeakIdx;

endmodule

// File: tb/tb_mult_leak_trial_sequencer.sv
// Directed bench for the trial sequencer with a small stub tester whose
// per-copy latency is set from the stimulus sequence.
module tb_mult_leak_trial_sequencer;

  localparam int WIDTH      = 64;
  localparam int NUM_TRIALS = 4;
  localparam int TIMEOUT    = 2*WIDTH+16;
  localparam int CNT_W      = $clog2(NUM_TRIALS+1);

  logic             clk;
  logic             rst_n;
  logic             run;
  logic [1:0]       mode;
  logic [31:0]      seed;
  logic [WIDTH-1:0] mulOne, mcOne, mulTwo, mcTwo;
  logic             mulStart;
  logic             timingLeak;
  logic             timingLeakDone;
  logic             busy;
  logic             campaignDone;
  logic [CNT_W-1:0] trialCount, leakCount, timeoutCount, firstLeakIdx;

  int passCount  = 0;
  int checkCount = 0;

  // Stub tester controls and state.
  int  stubLat       = 10;
  int  stubSlowTrial = -1;
  bit  stubNever     = 0;
  int  stubTrial     = 0;
  int  stubCur       = 0;
  int  stubCnt       = 0;
  bit  stubActive    = 0;
  logic done1, done2;

  mult_leak_trial_sequencer #(
    .WIDTH      (WIDTH),
    .NUM_TRIALS (NUM_TRIALS),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_run             (run),
    .i_mode            (mode),
    .i_seed            (seed),
    .o_multiplierOne   (mulOne),
    .o_multiplicandOne (mcOne),
    .o_multiplierTwo   (mulTwo),
    .o_multiplicandTwo (mcTwo),
    .o_mulStart        (mulStart),
    .i_timingLeak      (timingLeak),
    .i_timingLeakDone  (timingLeakDone),
    .o_busy            (busy),
    .o_campaignDone    (campaignDone),
    .o_trialCount      (trialCount),
    .o_leakCount       (leakCount),
    .o_timeoutCount    (timeoutCount),
    .o_firstLeakIdx    (firstLeakIdx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub tester: latency counted from the start pulse; the slow trial's
  // copy two finishes 3 cycles after copy one.
  always @(posedge clk) begin
    if (run) stubTrial <= 0;
    if (mulStart) begin
      stubActive <= 1'b1;
      stubCnt    <= 0;
      stubCur    <= stubTrial;
      stubTrial  <= stubTrial + 1;
    end else if (stubActive) begin
      stubCnt <= stubCnt + 1;
    end
  end

  assign done1 = stubActive && !stubNever && (stubCnt >= stubLat);
  assign done2 = stubActive && !stubNever &&
                 (stubCnt >= stubLat + ((stubCur == stubSlowTrial) ? 3 : 0));
  assign timingLeakDone = done1 | done2;
  assign timingLeak     = !(done1 && done2);

  function automatic logic [31:0] refNext(input logic [31:0] xin);
    logic [31:0] x;
    x = xin;
    x = x ^ (x << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

  // Reference operands for a given trial of a campaign.
  task automatic expectOps(input logic [31:0] s, input logic [1:0] m, input int trial,
                           output logic [63:0] a, output logic [63:0] b,
                           output logic [63:0] c, output logic [63:0] d);
    logic [31:0] x;
    logic [31:0] w [8];
    x = (s == 32'h0) ? 32'h1 : s;
    for (int i = 0; i < trial*8; i++) x = refNext(x);
    for (int i = 0; i < 8; i++) begin
      x = refNext(x);
      w[i] = x;
    end
    a = {w[1], w[0]};
    b = {w[3], w[2]};
    c = {w[5], w[4]};
    d = {w[7], w[6]};
    case (m)
      2'd1: d = 64'h0;
      2'd2: d = '1;
      2'd3: begin c = a; d = b; end
      default: ;
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [31:0] s);
    @(negedge clk);
    mode = m;
    seed = s;
    run  = 1'b1;
    @(negedge clk);
    run  = 1'b0;
  endtask

  task automatic waitMulStart(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mulStart && n < 400);
    if (!mulStart) checkOutput({tag, " start timeout"}, 64'd0, 64'd1);
  endtask

  task automatic waitCampaignDone(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!campaignDone && n < 1000);
    checkOutput({tag, " campaignDone"}, 64'(campaignDone), 64'd1);
  endtask

  task automatic checkOps(input string tag, input logic [31:0] s, input logic [1:0] m, input int trial);
    logic [63:0] a, b, c, d;
    expectOps(s, m, trial, a, b, c, d);
    checkOutput({tag, " mulOne"}, mulOne, a);
    checkOutput({tag, " mcOne"},  mcOne,  b);
    checkOutput({tag, " mulTwo"}, mulTwo, c);
    checkOutput({tag, " mcTwo"},  mcTwo,  d);
  endtask

  task automatic checkStats(input string tag, input int tc, input int lc, input int toc, input int fli);
    checkOutput({tag, " trialCount"},   64'(trialCount),   64'(tc));
    checkOutput({tag, " leakCount"},    64'(leakCount),    64'(lc));
    checkOutput({tag, " timeoutCount"}, 64'(timeoutCount), 64'(toc));
    checkOutput({tag, " firstLeakIdx"}, 64'(firstLeakIdx), 64'(fli));
  endtask

  localparam int NONE = (1 << CNT_W) - 1;

  initial begin
    int spacing;
    int extraDone;
    rst_n = 1'b0;
    run   = 1'b0;
    mode  = 2'd0;
    seed  = 32'h0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset mulStart", 64'(mulStart), 64'd0);
    checkOutput("reset campaignDone", 64'(campaignDone), 64'd0);
    checkOutput("reset mulOne", mulOne, 64'd0);
    checkOutput("reset mcTwo", mcTwo, 64'd0);
    checkStats("reset", 0, 0, 0, NONE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Campaign with identical copy latencies, mode 3.
    $display("[TB] identical latency, mode 3");
    stubLat = 10; stubSlowTrial = -1; stubNever = 0;
    applyStimulus(2'd3, 32'hDEADBEEF);
    checkOutput("mode3 busy", 64'(busy), 64'd1);
    for (int t = 0; t < NUM_TRIALS; t++) begin
      waitMulStart("mode3");
      checkOps($sformatf("mode3 t%0d", t), 32'hDEADBEEF, 2'd3, t);
    end
    waitCampaignDone("mode3");
    checkStats("mode3", 4, 0, 0, NONE);
    @(negedge clk);
    checkOutput("mode3 done pulse width", 64'(campaignDone), 64'd0);
    checkOutput("mode3 idle busy", 64'(busy), 64'd0);

    // Copy two lags by 3 cycles on trial 2 only.
    $display("[TB] leak on trial 2");
    stubSlowTrial = 2;
    applyStimulus(2'd0, 32'hA5A5A5A5);
    for (int t = 0; t < NUM_TRIALS; t++) begin
      waitMulStart("leak");
      checkOps($sformatf("leak t%0d", t), 32'hA5A5A5A5, 2'd0, t);
    end
    waitCampaignDone("leak");
    checkStats("leak", 4, 1, 0, 2);

    // Tester never finishes: every trial times out.
    $display("[TB] timeout campaign");
    stubSlowTrial = -1; stubNever = 1;
    applyStimulus(2'd2, 32'h0BADF00D);
    waitMulStart("timeout");
    checkOps("timeout t0", 32'h0BADF00D, 2'd2, 0);
    spacing = 0;
    do begin
      @(negedge clk);
      spacing++;
    end while (!mulStart && spacing < 400);
    checkOutput("timeout start spacing", 64'(spacing), 64'(1 + TIMEOUT + 1 + 8));
    waitMulStart("timeout");
    waitMulStart("timeout");
    waitCampaignDone("timeout");
    checkStats("timeout", 4, 4, 4, 0);

    // Seed 0 in mode 1: generator starts from 1.
    $display("[TB] seed 0, mode 1");
    stubNever = 0;
    applyStimulus(2'd1, 32'h0);
    for (int t = 0; t < NUM_TRIALS; t++) begin
      waitMulStart("seed0");
      if (t == 0) checkOutput("seed0 first word", 64'(mulOne[31:0]), 64'h0004_2021);
      checkOutput($sformatf("seed0 t%0d mcTwo zero", t), mcTwo, 64'd0);
      checkOps($sformatf("seed0 t%0d", t), 32'h0, 2'd1, t);
    end
    waitCampaignDone("seed0");
    checkStats("seed0", 4, 0, 0, NONE);

    // Reset asserted during trial 1's WAIT.
    $display("[TB] reset mid-campaign");
    stubLat = 30; stubSlowTrial = 0;
    applyStimulus(2'd0, 32'h13579BDF);
    waitMulStart("abort");
    waitMulStart("abort");
    repeat (5) @(negedge clk);
    checkStats("abort pre-reset", 1, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort mulOne", mulOne, 64'd0);
    checkOutput("abort mcOne", mcOne, 64'd0);
    checkStats("abort", 0, 0, 0, NONE);
    @(negedge clk);
    rst_n = 1'b1;
    extraDone = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (campaignDone || mulStart || busy) extraDone++;
    end
    checkOutput("abort no activity after reset", 64'(extraDone), 64'd0);
    stubLat = 10; stubSlowTrial = -1;
    applyStimulus(2'd0, 32'h12345678);
    checkStats("restart cleared", 0, 0, 0, NONE);
    for (int t = 0; t < NUM_TRIALS; t++) begin
      waitMulStart("restart");
      checkOps($sformatf("restart t%0d", t), 32'h12345678, 2'd0, t);
    end
    waitCampaignDone("restart");
    checkStats("restart", 4, 0, 0, NONE);

    // run pulsed mid-campaign must be ignored.
    $display("[TB] run while busy");
    applyStimulus(2'd3, 32'hCAFEF00D);
    waitMulStart("busyrun");
    checkOps("busyrun t0", 32'hCAFEF00D, 2'd3, 0);
    repeat (3) @(negedge clk);
    applyStimulus(2'd1, 32'h0);
    for (int t = 1; t < NUM_TRIALS; t++) begin
      waitMulStart("busyrun");
      checkOps($sformatf("busyrun t%0d", t), 32'hCAFEF00D, 2'd3, t);
    end
    waitCampaignDone("busyrun");
    checkStats("busyrun", 4, 0, 0, NONE);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
